// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths and types for the Sobel window front end.
package sobel_pkg;
    localparam int PIX_W = 8;
    localparam int K_W   = 9;
    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [0:2][0:2][K_W-1:0] window_t;
    typedef enum logic {WAIT_SOF, STREAM} state_e;
endpackage

// File: rtl/sobel_window_if.sv
// sobel_window_if: pixel stream in, registered 3x3 window plus status out.
interface sobel_window_if #(
    parameter int IMG_W = 352,
    parameter int IMG_H = 288,
    parameter int PIX_W = 8
);
    import sobel_pkg::*;
    logic                     sof;
    logic                     pix_valid;
    logic [PIX_W-1:0]         pix_in;
    logic [K_W-1:0]           w11, w12, w13, w21, w22, w23, w31, w32, w33;
    logic                     win_valid;
    logic [$clog2(IMG_W)-1:0] win_x;
    logic [$clog2(IMG_H)-1:0] win_y;
    logic                     frame_done;
    logic                     frame_err;
    modport master (
        output sof, pix_valid, pix_in,
        input  w11, w12, w13, w21, w22, w23, w31, w32, w33,
        input  win_valid, win_x, win_y, frame_done, frame_err
    );
    modport slave (
        input  sof, pix_valid, pix_in,
        output w11, w12, w13, w21, w22, w23, w31, w32, w33,
        output win_valid, win_x, win_y, frame_done, frame_err
    );
endinterface

// File: rtl/sobel_window_line_buffer.sv
// line_buffer: one line of pixels, combinational read-before-write, no reset.
module line_buffer #(
    parameter int DEPTH = 352,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_addr] <= i_wdata;
endmodule

// File: rtl/sobel_window.sv
// sobel_window: raster stream to registered 3x3 windows for every interior pixel.
module sobel_window
    import sobel_pkg::*;
#(
    parameter int IMG_W = 352,
    parameter int IMG_H = 288,
    parameter int PIX_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    sobel_window_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_e           r_state;
    logic [CW-1:0]    r_col, r_x;
    logic [RW-1:0]    r_row, r_y;
    window_t          r_win;
    logic             r_valid, r_done, r_err;
    logic             w_acc, w_last, w_eol;
    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic [PIX_W-1:0] w_t, w_m;

    // sof restarts the coordinates on the very pixel that carries it
    assign w_acc  = bus.pix_valid && (r_state == STREAM || bus.sof);
    assign w_col  = bus.sof ? '0 : r_col;
    assign w_row  = bus.sof ? '0 : r_row;
    assign w_eol  = w_col == CW'(IMG_W - 1);
    assign w_last = w_eol && w_row == RW'(IMG_H - 1);

    line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb_top (
        .clk(clk), .i_we(w_acc), .i_addr(w_col), .i_wdata(w_m), .o_rdata(w_t)
    );
    line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb_mid (
        .clk(clk), .i_we(w_acc), .i_addr(w_col), .i_wdata(bus.pix_in), .o_rdata(w_m)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= WAIT_SOF;
            r_col   <= '0;
            r_row   <= '0;
            r_win   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_valid <= w_acc && !bus.sof && w_row >= RW'(2) && w_col >= CW'(2);
            r_done  <= w_acc && w_last;
            r_err   <= w_acc && bus.sof && r_state == STREAM;
            if (w_acc) begin
                r_win[0] <= {r_win[0][1:2], K_W'(w_t)};
                r_win[1] <= {r_win[1][1:2], K_W'(w_m)};
                r_win[2] <= {r_win[2][1:2], K_W'(bus.pix_in)};
                r_x      <= w_col - 1'b1;
                r_y      <= w_row - 1'b1;
                r_col    <= w_eol ? '0 : w_col + 1'b1;
                r_row    <= w_last ? '0 : w_eol ? w_row + 1'b1 : w_row;
                r_state  <= w_last ? WAIT_SOF : STREAM;
            end
        end

    assign bus.w11        = r_win[0][0];
    assign bus.w12        = r_win[0][1];
    assign bus.w13        = r_win[0][2];
    assign bus.w21        = r_win[1][0];
    assign bus.w22        = r_win[1][1];
    assign bus.w23        = r_win[1][2];
    assign bus.w31        = r_win[2][0];
    assign bus.w32        = r_win[2][1];
    assign bus.w33        = r_win[2][2];
    assign bus.win_valid  = r_valid;
    assign bus.win_x      = r_x;
    assign bus.win_y      = r_y;
    assign bus.frame_done = r_done;
    assign bus.frame_err  = r_err;
endmodule

// File: tb/tb_sobel_window.sv
// tb_sobel_window: 4x3 frames against a frame-array model plus literal window tables.
module tb_sobel_window;
    import sobel_pkg::*;
    localparam int W = 4;
    localparam int H = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sobel_window_if #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) bus ();
    sobel_window #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int w [9];
        int x, y, d;
    } cap_t;

    int   nchk = 0, nerr = 0, nferr = 0;
    cap_t cap [$];
    int   img [H][W];
    int   ew [9];
    int   ev = 0, ed = 0, ee = 0, ex = 0, ey = 0;
    int   act [9];

    always_comb begin
        act[0] = int'(bus.w11); act[1] = int'(bus.w12); act[2] = int'(bus.w13);
        act[3] = int'(bus.w21); act[4] = int'(bus.w22); act[5] = int'(bus.w23);
        act[6] = int'(bus.w31); act[7] = int'(bus.w32); act[8] = int'(bus.w33);
    end

    function automatic void chk(string n, int a, int e);
        nchk++;
        if (a != e) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endfunction

    // frame model: store accepted pixels by coordinate, cut windows out of the array
    initial begin
        int mr, mc, ms;
        mr = 0; mc = 0; ms = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mr = 0; mc = 0; ms = 0;
                ev = 0; ed = 0; ee = 0;
            end else begin
                ev = 0; ed = 0; ee = 0;
                if (bus.pix_valid && (ms == 1 || bus.sof)) begin
                    if (bus.sof) begin
                        ee = ms;
                        mr = 0;
                        mc = 0;
                    end
                    img[mr][mc] = int'(bus.pix_in);
                    if (mr >= 2 && mc >= 2) begin
                        ev = 1;
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++) ew[3*i+j] = img[mr-2+i][mc-2+j];
                        ex = mc - 1;
                        ey = mr - 1;
                        ed = (mr == H - 1 && mc == W - 1) ? 1 : 0;
                    end
                    mc++;
                    if (mc == W) begin mc = 0; mr++; end
                    if (mr == H) begin mr = 0; ms = 0; end else ms = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("win_valid", int'(bus.win_valid), ev);
            chk("frame_done", int'(bus.frame_done), ed);
            chk("frame_err", int'(bus.frame_err), ee);
            if (ev == 1) begin
                for (int k = 0; k < 9; k++) chk($sformatf("w[%0d]", k), act[k], ew[k]);
                chk("win_x", int'(bus.win_x), ex);
                chk("win_y", int'(bus.win_y), ey);
            end
            if (bus.win_valid) begin
                cap_t c;
                c.w = act;
                c.x = int'(bus.win_x);
                c.y = int'(bus.win_y);
                c.d = int'(bus.frame_done);
                cap.push_back(c);
            end
            if (bus.frame_err) nferr++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send(input logic s, input int p, input int gaps);
        bus.sof = s;
        bus.pix_valid = 1'b1;
        bus.pix_in = 8'(p);
        idle(1);
        bus.sof = 1'b0;
        bus.pix_valid = 1'b0;
        idle(gaps);
    endtask

    function automatic int pix(input int r, input int c, input int v22);
        return (r == 2 && c == 2) ? v22 : 10 * r + c;
    endfunction

    task automatic frame(input int gaps, input int v22);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) send(r == 0 && c == 0, pix(r, c, v22), gaps);
    endtask

    task automatic check_s1(input string tag, input int v22);
        int e [2][9];
        e = '{'{0, 1, 2, 10, 11, 12, 20, 21, 22}, '{1, 2, 3, 11, 12, 13, 21, 22, 23}};
        e[0][8] = v22;
        e[1][7] = v22;
        idle(3);
        chk({tag, " count"}, cap.size(), 2);
        for (int k = 0; k < 2 && k < cap.size(); k++) begin
            for (int i = 0; i < 9; i++) chk($sformatf("%s win%0d w[%0d]", tag, k, i), cap[k].w[i], e[k][i]);
            chk($sformatf("%s win%0d x", tag, k), cap[k].x, k + 1);
            chk($sformatf("%s win%0d y", tag, k), cap[k].y, 1);
            chk($sformatf("%s win%0d done", tag, k), cap[k].d, k);
        end
        cap.delete();
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 9; k++) chk($sformatf("%s w[%0d]", tag, k), act[k], 0);
        chk({tag, " win_valid"}, int'(bus.win_valid), 0);
        chk({tag, " win_x"}, int'(bus.win_x), 0);
        chk({tag, " win_y"}, int'(bus.win_y), 0);
        chk({tag, " frame_done"}, int'(bus.frame_done), 0);
        chk({tag, " frame_err"}, int'(bus.frame_err), 0);
    endtask

    initial begin
        pix_t p55;
        p55 = 8'h55;
        rst_n = 1'b0;
        bus.sof = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in = '0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        #1 rst_n = 1'b1;
        idle(2);

        frame(0, 22);
        check_s1("ramp", 22);

        frame(3, 22);
        check_s1("gaps", 22);

        for (int i = 0; i < 3; i++) send(1'b0, int'(p55), 0);
        idle(3);
        chk("no sof windows", cap.size(), 0);
        frame(0, 22);
        check_s1("after junk", 22);

        frame(0, 255);
        check_s1("w33 zext", 255);

        for (int i = 0; i < 6; i++) send(i == 0, pix(i / W, i % W, 22), 0);
        nferr = 0;
        frame(0, 22);
        chk("frame_err pulses", nferr, 1);
        check_s1("restart", 22);

        for (int i = 0; i < 10; i++) send(i == 0, pix(i / W, i % W, 22), 0);
        chk("pre-reset w33", act[8], 21);
        rst_n = 1'b0;
        #1 check_zero("async reset");
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("post-reset windows", cap.size(), 0);
        frame(0, 22);
        check_s1("post reset", 22);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
